// File: rtl/spi_pkg.sv
// Shared definitions for the single-byte SPI master: mode encodings, mode
// decode helpers, the byte width and the control FSM state type.
package spi_pkg;

    localparam int SPI_BYTE_W = 8;

    localparam logic [1:0] SPI_MODE0 = 2'd0;
    localparam logic [1:0] SPI_MODE1 = 2'd1;
    localparam logic [1:0] SPI_MODE2 = 2'd2;
    localparam logic [1:0] SPI_MODE3 = 2'd3;

    typedef enum logic [1:0] {
        ST_RESET = 2'd0,
        ST_IDLE  = 2'd1,
        ST_XFER  = 2'd2
    } spi_state_t;

    function automatic logic cpol(input logic [1:0] mode);
        return mode[1];
    endfunction

    function automatic logic cpha(input logic [1:0] mode);
        return mode[0];
    endfunction

endpackage

// File: rtl/spi_master_if.sv
// Byte-stream handshake plus the serial wires of the SPI master, bundled so
// the parent and the bench connect one object.
interface spi_master_if;
    import spi_pkg::*;

    // Handshake: a byte transfers on a rising r_clk edge where r_data_ready
    // and w_data_ready are both 1; r_data_ready while w_data_ready is 0 is
    // dropped, never queued. w_master_done is a one-clock result strobe.
    logic [SPI_BYTE_W-1:0] r_data;
    logic                  r_data_ready;
    logic                  w_data_ready;
    logic                  w_master_done;
    logic [SPI_BYTE_W-1:0] w_data;
    logic                  w_clk;
    logic                  r_miso;
    logic                  w_mosi;

    modport master (
        input  r_data, r_data_ready, r_miso,
        output w_data_ready, w_master_done, w_data, w_clk, w_mosi
    );

    modport slave (
        output r_data, r_data_ready, r_miso,
        input  w_data_ready, w_master_done, w_data, w_clk, w_mosi
    );

endinterface

// File: rtl/spi_clk_gen.sv
// SPI clock generator: a half-bit counter paces 16 w_clk toggles per byte and
// reports each toggle as a one-cycle leading or trailing strobe.
module spi_clk_gen #(
    parameter logic CPOL              = 1'b0,
    parameter int   CLKS_PER_HALF_BIT = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic spi_clk,
    output logic leading_edge,
    output logic trailing_edge,
    output logic busy
);

    localparam int            CW       = $clog2(2 * CLKS_PER_HALF_BIT);
    localparam logic [CW-1:0] LEAD_AT  = CW'(CLKS_PER_HALF_BIT - 1);
    localparam logic [CW-1:0] TRAIL_AT = CW'(2 * CLKS_PER_HALF_BIT - 1);

    logic [CW-1:0] half_cnt;
    logic [4:0]    edge_cnt;

    assign busy          = (edge_cnt != 5'd0);
    assign leading_edge  = busy && (half_cnt == LEAD_AT);
    assign trailing_edge = busy && (half_cnt == TRAIL_AT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            half_cnt <= '0;
            edge_cnt <= 5'd0;
            spi_clk  <= CPOL;
        end else if (start) begin
            half_cnt <= '0;
            edge_cnt <= 5'd16;
        end else if (busy) begin
            // Wrap at the trailing edge so the count also works when
            // 2*CLKS_PER_HALF_BIT is not a power of two.
            half_cnt <= trailing_edge ? '0 : half_cnt + 1'b1;
            if (leading_edge || trailing_edge) begin
                spi_clk  <= ~spi_clk;
                edge_cnt <= edge_cnt - 5'd1;
            end
        end
    end

endmodule

// File: rtl/spi_master.sv
// Single-byte SPI master: accepts a byte over a valid/ready handshake, shifts
// it out MSB first on w_mosi while shifting in r_miso, then pulses done.
module spi_master
    import spi_pkg::*;
#(
    parameter logic [1:0] SPI_MODE          = SPI_MODE0,
    parameter int         CLKS_PER_HALF_BIT = 2
) (
    input  logic         r_clk,
    input  logic         r_reset,
    spi_master_if.master bus,
    output spi_state_t   dbg_state
);

    localparam logic CPOL = cpol(SPI_MODE);
    localparam logic CPHA = cpha(SPI_MODE);

    spi_state_t state, state_next;

    logic                  accept, busy, spi_clk, leading_edge, trailing_edge;
    logic                  drive_edge, sample_edge, drive_now;
    logic                  load_q, last_sample_q, done_q, mosi_q;
    logic [SPI_BYTE_W-1:0] tx_shift, rx_shift, rx_byte;
    logic [3:0]            tx_cnt;
    logic [2:0]            rx_cnt;

    assign accept      = (state == ST_IDLE) && bus.r_data_ready;
    assign drive_edge  = CPHA ? leading_edge : trailing_edge;
    assign sample_edge = CPHA ? trailing_edge : leading_edge;
    // CPHA=0 presents the MSB right after accept; the 8th trailing edge must
    // not drive, so the line keeps the LSB between bytes.
    assign drive_now   = (load_q && !CPHA) || (drive_edge && (tx_cnt < 4'd8));

    spi_clk_gen #(
        .CPOL              (CPOL),
        .CLKS_PER_HALF_BIT (CLKS_PER_HALF_BIT)
    ) u_clk_gen (
        .clk           (r_clk),
        .rst           (r_reset),
        .start         (accept),
        .spi_clk       (spi_clk),
        .leading_edge  (leading_edge),
        .trailing_edge (trailing_edge),
        .busy          (busy)
    );

    always_ff @(posedge r_clk or posedge r_reset) begin
        if (r_reset) state <= ST_RESET;
        else         state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_RESET: state_next = ST_IDLE;
            ST_IDLE:  if (bus.r_data_ready) state_next = ST_XFER;
            ST_XFER:  if (!busy) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge r_clk or posedge r_reset) begin
        if (r_reset) begin
            load_q        <= 1'b0;
            last_sample_q <= 1'b0;
            done_q        <= 1'b0;
            mosi_q        <= 1'b0;
            tx_shift      <= '0;
            rx_shift      <= '0;
            rx_byte       <= '0;
            tx_cnt        <= 4'd0;
            rx_cnt        <= 3'd0;
        end else begin
            load_q        <= accept;
            last_sample_q <= 1'b0;
            done_q        <= last_sample_q;
            if (accept) begin
                tx_shift <= bus.r_data;
                tx_cnt   <= 4'd0;
                rx_cnt   <= 3'd0;
            end else begin
                if (drive_now) begin
                    mosi_q   <= tx_shift[SPI_BYTE_W-1];
                    tx_shift <= {tx_shift[SPI_BYTE_W-2:0], 1'b0};
                    tx_cnt   <= tx_cnt + 4'd1;
                end
                if (sample_edge) begin
                    rx_shift <= {rx_shift[SPI_BYTE_W-2:0], bus.r_miso};
                    rx_cnt   <= rx_cnt + 3'd1;
                    if (rx_cnt == 3'd7) last_sample_q <= 1'b1;
                end
            end
            if (last_sample_q) rx_byte <= rx_shift;
        end
    end

    assign bus.w_data_ready  = (state == ST_IDLE);
    assign bus.w_master_done = done_q;
    assign bus.w_data        = rx_byte;
    assign bus.w_clk         = spi_clk;
    assign bus.w_mosi        = mosi_q;
    assign dbg_state         = state;

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: three instances (mode 3 / mode 0 loopback at two
// clocks per half bit, mode 1 at four against a model slave) driven in turn.
module tb_spi_master;
    import spi_pkg::*;

    localparam logic [2:0] CPOL_V = 3'b001;
    localparam logic [2:0] CPHA_V = 3'b101;

    logic r_clk;
    logic r_reset;
    int   cyc;
    int   check_cnt;
    int   pass_cnt;

    spi_master_if bus0 ();
    spi_master_if bus1 ();
    spi_master_if bus2 ();
    spi_state_t   dbg0, dbg1, dbg2;

    spi_master #(.SPI_MODE(SPI_MODE3), .CLKS_PER_HALF_BIT(2)) dut_m3 (
        .r_clk(r_clk), .r_reset(r_reset), .bus(bus0), .dbg_state(dbg0));
    spi_master #(.SPI_MODE(SPI_MODE0), .CLKS_PER_HALF_BIT(2)) dut_m0 (
        .r_clk(r_clk), .r_reset(r_reset), .bus(bus1), .dbg_state(dbg1));
    spi_master #(.SPI_MODE(SPI_MODE1), .CLKS_PER_HALF_BIT(4)) dut_m1 (
        .r_clk(r_clk), .r_reset(r_reset), .bus(bus2), .dbg_state(dbg2));

    // Loopback on the first two, model slave on the third.
    logic       slave_bit;
    int         slave_idx;
    logic [7:0] slave_pat;
    assign bus0.r_miso = bus0.w_mosi;
    assign bus1.r_miso = bus1.w_mosi;
    assign bus2.r_miso = slave_bit;

    // Mode 1 slave: present the next pattern bit on each rising w_clk.
    always @(posedge bus2.w_clk) begin
        if (slave_idx < 8) begin
            slave_bit = slave_pat[7 - slave_idx];
            slave_idx++;
        end
    end

    // ---------------- clock / reset ----------------
    initial begin
        r_clk = 1'b0;
        forever #5 r_clk = ~r_clk;
    end

    always @(posedge r_clk) cyc++;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- observed signal vectors ----------------
    logic [2:0] clk_v, mosi_v, done_v, rdy_v;
    logic [7:0] data_v [3];
    assign clk_v  = {bus2.w_clk, bus1.w_clk, bus0.w_clk};
    assign mosi_v = {bus2.w_mosi, bus1.w_mosi, bus0.w_mosi};
    assign done_v = {bus2.w_master_done, bus1.w_master_done, bus0.w_master_done};
    assign rdy_v  = {bus2.w_data_ready, bus1.w_data_ready, bus0.w_data_ready};
    assign data_v[0] = bus0.w_data;
    assign data_v[1] = bus1.w_data;
    assign data_v[2] = bus2.w_data;

    // ---------------- scoreboard ----------------
    logic [7:0] exp_q0 [$];
    logic [7:0] exp_q1 [$];
    logic [7:0] exp_q2 [$];

    int         tog_cnt [3];
    int         done_cnt [3];
    int         first_tog [3];
    int         last_tog [3];
    int         min_gap [3];
    int         max_gap [3];
    int         accept_cyc [3];
    logic       first_mosi [3];
    logic [7:0] mosi_cap [3];
    logic [2:0] prev_clk, prev_mosi;

    task automatic chk(input string tag, input int sel, input logic [31:0] obs,
                       input logic [31:0] exp);
        check_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s dut%0d observed=0x%0h expected=0x%0h", tag, sel, obs, exp);
    endtask

    // Monitor samples 1 time unit after each rising edge.
    always @(posedge r_clk) begin
        #1;
        for (int i = 0; i < 3; i++) begin
            if (clk_v[i] != prev_clk[i]) begin
                tog_cnt[i]++;
                if (tog_cnt[i] == 1) begin
                    first_tog[i]  = cyc;
                    first_mosi[i] = prev_mosi[i];
                end else begin
                    if (cyc - last_tog[i] < min_gap[i]) min_gap[i] = cyc - last_tog[i];
                    if (cyc - last_tog[i] > max_gap[i]) max_gap[i] = cyc - last_tog[i];
                end
                last_tog[i] = cyc;
                if ((clk_v[i] != CPOL_V[i]) == !CPHA_V[i])
                    mosi_cap[i] = {mosi_cap[i][6:0], prev_mosi[i]};
            end
            if (done_v[i]) begin
                logic [7:0] exp_b;
                logic       have;
                done_cnt[i]++;
                have  = 1'b0;
                exp_b = 8'h00;
                case (i)
                    0: if (exp_q0.size() > 0) begin have = 1'b1; exp_b = exp_q0.pop_front(); end
                    1: if (exp_q1.size() > 0) begin have = 1'b1; exp_b = exp_q1.pop_front(); end
                    default: if (exp_q2.size() > 0) begin have = 1'b1; exp_b = exp_q2.pop_front(); end
                endcase
                chk("done_expected", i, 32'(have), 32'd1);
                if (have) chk("rx_byte", i, 32'(data_v[i]), 32'(exp_b));
            end
        end
        prev_clk  = clk_v;
        prev_mosi = mosi_v;
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge r_clk);
    endtask

    task automatic clear_mon(input int sel);
        tog_cnt[sel]   = 0;
        done_cnt[sel]  = 0;
        first_tog[sel] = 0;
        last_tog[sel]  = 0;
        min_gap[sel]   = 1000;
        max_gap[sel]   = 0;
        mosi_cap[sel]  = 8'h00;
        first_mosi[sel] = 1'b0;
    endtask

    task automatic set_req(input int sel, input logic [7:0] b, input logic v);
        case (sel)
            0: begin bus0.r_data = b; bus0.r_data_ready = v; end
            1: begin bus1.r_data = b; bus1.r_data_ready = v; end
            default: begin bus2.r_data = b; bus2.r_data_ready = v; end
        endcase
    endtask

    // Called at a negedge with w_data_ready high, so the next edge accepts.
    task automatic send(input int sel, input logic [7:0] b, input logic push,
                        input logic [7:0] exp_rx);
        set_req(sel, b, 1'b1);
        if (push) begin
            case (sel)
                0: exp_q0.push_back(exp_rx);
                1: exp_q1.push_back(exp_rx);
                default: exp_q2.push_back(exp_rx);
            endcase
        end
        @(negedge r_clk);
        accept_cyc[sel] = cyc;
        set_req(sel, b, 1'b0);
    endtask

    task automatic wait_ready(input int sel, input int budget);
        int n = 0;
        while (!rdy_v[sel] && n < budget) begin
            @(negedge r_clk);
            n++;
        end
        chk("ready_return", sel, 32'(rdy_v[sel]), 32'd1);
    endtask

    task automatic wait_done(input int sel, input int cnt, input int budget);
        int n = 0;
        while (done_cnt[sel] < cnt && n < budget) begin
            @(negedge r_clk);
            n++;
        end
        chk("done_timeout", sel, 32'(done_cnt[sel] >= cnt), 32'd1);
    endtask

    task automatic wait_toggles(input int sel, input int cnt, input int budget);
        int n = 0;
        while (tog_cnt[sel] < cnt && n < budget) begin
            @(negedge r_clk);
            n++;
        end
        chk("toggle_timeout", sel, 32'(tog_cnt[sel]), 32'(cnt));
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        check_cnt = 0;
        pass_cnt  = 0;
        cyc       = 0;
        slave_idx = 8;
        slave_bit = 1'b0;
        slave_pat = 8'h96;
        prev_clk  = CPOL_V;
        prev_mosi = 3'b000;
        for (int i = 0; i < 3; i++) begin
            clear_mon(i);
            accept_cyc[i] = 0;
            set_req(i, 8'h00, 1'b0);
        end
        r_reset = 1'b1;

        // Reset values, with a request pending that must be lost.
        set_req(1, 8'hEE, 1'b1);
        tick(2);
        for (int i = 0; i < 3; i++) begin
            chk("rst_w_clk", i, 32'(clk_v[i]), 32'(CPOL_V[i]));
            chk("rst_w_mosi", i, 32'(mosi_v[i]), 32'd0);
            chk("rst_w_data", i, 32'(data_v[i]), 32'd0);
            chk("rst_done", i, 32'(done_v[i]), 32'd0);
            chk("rst_ready", i, 32'(rdy_v[i]), 32'd0);
        end
        chk("rst_state", 0, 32'(dbg0), 32'(ST_RESET));
        set_req(1, 8'h00, 1'b0);
        r_reset = 1'b0;
        tick(1);
        for (int i = 0; i < 3; i++) chk("ready_after_reset", i, 32'(rdy_v[i]), 32'd1);
        chk("lost_request_no_toggle", 1, 32'(tog_cnt[1]), 32'd0);

        // Mode 3 loopback, 0xC1.
        clear_mon(0);
        chk("m3_idle_clk", 0, 32'(clk_v[0]), 32'd1);
        send(0, 8'hC1, 1'b1, 8'hC1);
        wait_done(0, 1, 200);
        wait_ready(0, 50);
        tick(3);
        chk("m3_toggles", 0, 32'(tog_cnt[0]), 32'd16);
        chk("m3_min_gap", 0, 32'(min_gap[0]), 32'd2);
        chk("m3_max_gap", 0, 32'(max_gap[0]), 32'd2);
        chk("m3_first_edge", 0, 32'(first_tog[0] - accept_cyc[0]), 32'd2);
        chk("m3_mosi_bits", 0, 32'(mosi_cap[0]), 32'hC1);
        chk("m3_done_count", 0, 32'(done_cnt[0]), 32'd1);
        chk("m3_end_clk", 0, 32'(clk_v[0]), 32'd1);

        // Mode 0 loopback, 0xA5.
        clear_mon(1);
        chk("m0_idle_clk", 1, 32'(clk_v[1]), 32'd0);
        send(1, 8'hA5, 1'b1, 8'hA5);
        wait_done(1, 1, 200);
        wait_ready(1, 50);
        tick(3);
        chk("m0_msb_before_edge", 1, 32'(first_mosi[1]), 32'd1);
        chk("m0_mosi_bits", 1, 32'(mosi_cap[1]), 32'hA5);
        chk("m0_toggles", 1, 32'(tog_cnt[1]), 32'd16);
        chk("m0_done_count", 1, 32'(done_cnt[1]), 32'd1);

        // Back-to-back 0x3C then 0x81.
        clear_mon(1);
        send(1, 8'h3C, 1'b1, 8'h3C);
        wait_ready(1, 100);
        send(1, 8'h81, 1'b1, 8'h81);
        wait_done(1, 2, 200);
        wait_ready(1, 50);
        tick(3);
        chk("b2b_done_count", 1, 32'(done_cnt[1]), 32'd2);
        chk("b2b_toggles", 1, 32'(tog_cnt[1]), 32'd32);
        chk("b2b_min_gap", 1, 32'(min_gap[1]), 32'd2);
        chk("b2b_max_gap", 1, 32'(max_gap[1]), 32'd4);
        chk("b2b_last_bits", 1, 32'(mosi_cap[1]), 32'h81);

        // Request while busy is ignored.
        clear_mon(1);
        send(1, 8'h12, 1'b1, 8'h12);
        tick(5);
        set_req(1, 8'hFF, 1'b1);
        tick(10);
        set_req(1, 8'h00, 1'b0);
        wait_done(1, 1, 200);
        wait_ready(1, 50);
        tick(5);
        chk("busy_done_count", 1, 32'(done_cnt[1]), 32'd1);
        chk("busy_toggles", 1, 32'(tog_cnt[1]), 32'd16);
        chk("busy_mosi_bits", 1, 32'(mosi_cap[1]), 32'h12);

        // Reset after six w_clk edges, then a clean transfer.
        clear_mon(1);
        send(1, 8'h77, 1'b0, 8'h00);
        wait_toggles(1, 6, 100);
        r_reset = 1'b1;
        tick(1);
        chk("midrst_w_clk", 1, 32'(clk_v[1]), 32'd0);
        chk("midrst_w_mosi", 1, 32'(mosi_v[1]), 32'd0);
        chk("midrst_ready", 1, 32'(rdy_v[1]), 32'd0);
        chk("midrst_done", 1, 32'(done_v[1]), 32'd0);
        tick(2);
        r_reset = 1'b0;
        tick(40);
        chk("midrst_no_done", 1, 32'(done_cnt[1]), 32'd0);
        chk("midrst_ready_back", 1, 32'(rdy_v[1]), 32'd1);
        clear_mon(1);
        send(1, 8'h5A, 1'b1, 8'h5A);
        wait_done(1, 1, 200);
        wait_ready(1, 50);
        tick(3);
        chk("post_rst_done_count", 1, 32'(done_cnt[1]), 32'd1);
        chk("post_rst_mosi_bits", 1, 32'(mosi_cap[1]), 32'h5A);

        // Mode 1, four clocks per half bit, model slave returns 0x96.
        clear_mon(2);
        slave_idx = 0;
        send(2, 8'h3C, 1'b1, 8'h96);
        wait_done(2, 1, 300);
        wait_ready(2, 50);
        tick(3);
        chk("m1_toggles", 2, 32'(tog_cnt[2]), 32'd16);
        chk("m1_min_gap", 2, 32'(min_gap[2]), 32'd4);
        chk("m1_max_gap", 2, 32'(max_gap[2]), 32'd4);
        chk("m1_first_edge", 2, 32'(first_tog[2] - accept_cyc[2]), 32'd4);
        chk("m1_byte_length", 2, 32'(last_tog[2] - accept_cyc[2]), 32'd64);
        chk("m1_mosi_bits", 2, 32'(mosi_cap[2]), 32'h3C);
        chk("m1_done_count", 2, 32'(done_cnt[2]), 32'd1);

        chk("queue0_empty", 0, 32'(exp_q0.size()), 32'd0);
        chk("queue1_empty", 1, 32'(exp_q1.size()), 32'd0);
        chk("queue2_empty", 2, 32'(exp_q2.size()), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule

// File: doc/spi_master.md
Name: spi_master

Overview:
- Single-byte SPI master. Serialises one parallel byte MSB-first on w_mosi and simultaneously deserialises one byte from r_miso.
- Generates the SPI clock w_clk from the system clock, with CPOL/CPHA selected by parameter.
- Sits between a byte-stream producer/consumer (valid/ready handshake) and an external SPI slave. Chip select is out of scope and handled by the parent.

Parameters:
- SPI_MODE, default 0: SPI mode 0..3. CPOL = SPI_MODE[1], CPHA = SPI_MODE[0].
- CLKS_PER_HALF_BIT, default 2: system clocks per half SPI bit period. Must be >= 2. One byte lasts 16*CLKS_PER_HALF_BIT clocks.

Ports:
- r_clk  input  1  system clock; all logic on its rising edge.
- r_reset  input  1  asynchronous, active-high reset.
- r_data  input  8  byte to transmit; sampled on the accept cycle.
- r_data_ready  input  1  transmit request strobe from the producer.
- w_data_ready  output  1  high when idle and able to accept a byte.
- w_master_done  output  1  one-clock pulse; received byte is valid on w_data.
- w_data  output  8  received byte; held until the next done pulse.
- w_clk  output  1  SPI serial clock.
- r_miso  input  1  serial data from the slave.
- w_mosi  output  1  serial data to the slave.

Behaviour:
- Interface: one clock (r_clk); reset r_reset is asynchronous, active-high.
- Reset values while r_reset = 1: w_clk = CPOL, w_mosi = 0, w_data = 0, w_master_done = 0, w_data_ready = 0, all counters and shift registers cleared.
- Leaving reset: w_data_ready rises on the first clock edge after r_reset deasserts.
- Accept: a byte is accepted on a clock edge where r_data_ready = 1 and w_data_ready = 1. On that edge:
  - r_data is latched into the TX shift register.
  - w_data_ready drops.
  - the edge counter loads 16.
- r_data_ready while busy (w_data_ready = 0) is ignored; no queueing.
- Clock generation:
  - A half-bit counter runs from 0 to 2*CLKS_PER_HALF_BIT-1.
  - A leading edge (w_clk toggles away from CPOL) occurs when the counter equals CLKS_PER_HALF_BIT-1.
  - A trailing edge (w_clk toggles back to CPOL) occurs at 2*CLKS_PER_HALF_BIT-1.
  - First leading edge: CLKS_PER_HALF_BIT clocks after the accept edge.
  - Exactly 16 toggles (8 full SPI cycles) per byte; w_clk ends at CPOL.
- CPHA = 0:
  - MSB is driven on w_mosi on the clock after accept, before the first leading edge.
  - Next bit is driven on each trailing edge.
  - r_miso is sampled on each leading edge.
- CPHA = 1:
  - Each bit, MSB first, is driven on a leading edge.
  - r_miso is sampled on each trailing edge.
- RX: sampled bits shift in MSB first; bit 7 is the first bit sampled.
- Done: on the clock after the 8th sample, w_data takes the full byte and w_master_done pulses for exactly one clock.
- Return to idle: w_data_ready returns to 1 one clock after the final (16th) w_clk edge. A new byte may be accepted on that same edge, so back-to-back transfers are allowed.
- Idle line state: w_mosi holds its last driven value between bytes.
- Reset mid-transfer: the transfer aborts immediately, outputs take their reset values, no done pulse is produced, and the partial RX byte is discarded.
- Simultaneous reset and r_data_ready: reset wins and the request is lost.

Decomposition:
- Shared package spi_pkg:
  - SPI mode constants SPI_MODE0..SPI_MODE3.
  - Helper functions cpol(mode) and cpha(mode).
  - Byte width constant SPI_BYTE_W = 8.
- One natural sub-module, spi_clk_gen:
  - Contains the half-bit counter, the 16-edge counter and w_clk generation.
  - Outputs one-cycle leading_edge and trailing_edge strobes plus a busy flag.
- The top level holds the handshake, the TX/RX shift registers and done generation.

Test Plan:
- SPI_MODE=3, CLKS_PER_HALF_BIT=2, w_mosi looped to r_miso, send 0xC1 after reset -> w_clk idles 1 and makes 16 toggles 2 clocks apart; w_mosi carries 1,1,0,0,0,0,0,1; one w_master_done pulse with w_data = 0xC1; w_data_ready returns to 1.
- SPI_MODE=0 loopback, send 0xA5 -> w_clk idles 0, MSB present before the first rising edge, w_data = 0xA5, exactly one done pulse.
- Back-to-back: send 0x3C, then 0x81 on the cycle w_data_ready rises -> two done pulses with w_data 0x3C then 0x81; 32 w_clk toggles with no gap beyond a single idle clock.
- Busy ignore: assert r_data_ready with 0xFF mid-transfer of 0x12 -> only 0x12 is transmitted; a single done pulse; 0xFF is never shifted.
- Reset mid-transfer: assert r_reset after 6 w_clk edges -> w_clk = CPOL, w_mosi = 0, w_data_ready = 0 during reset, no done pulse; the next transfer of 0x5A completes correctly.
- SPI_MODE=1, CLKS_PER_HALF_BIT=4, r_miso tied to constant pattern 0x96 from a model slave -> edges 4 clocks apart, byte lasts 64 clocks, w_data = 0x96.
